// File: rtl/bp_lce_req_serializer_if.sv
// Request-side and link-side signal bundle for the LCE request serializer.
// The master modport is the producer of requests and the consumer of flits;
// the slave modport is the serializer itself.
interface bp_lce_req_serializer_if #(
  parameter int hdr_width_p  = 64,
  parameter int data_width_p = 512,
  parameter int flit_width_p = 64
);

  // Request side (ready-then-valid)
  logic [hdr_width_p-1:0]  lce_req_header_i;
  logic [data_width_p-1:0] lce_req_data_i;
  logic [2:0]              lce_req_size_i;
  logic                    lce_req_has_data_i;
  logic                    lce_req_v_i;
  logic                    lce_req_ready_o;

  // Link side (valid-ready)
  logic [flit_width_p-1:0] link_data_o;
  logic                    link_hdr_o;
  logic                    link_last_o;
  logic                    link_v_o;
  logic                    link_ready_i;

  modport master (
    output lce_req_header_i, lce_req_data_i, lce_req_size_i,
           lce_req_has_data_i, lce_req_v_i, link_ready_i,
    input  lce_req_ready_o, link_data_o, link_hdr_o, link_last_o, link_v_o
  );

  modport slave (
    input  lce_req_header_i, lce_req_data_i, lce_req_size_i,
           lce_req_has_data_i, lce_req_v_i, link_ready_i,
    output lce_req_ready_o, link_data_o, link_hdr_o, link_last_o, link_v_o
  );

endinterface

// File: rtl/bp_lce_req_serializer.sv
// Serializes one BedRock LCE request (header + data) into a header flit
// followed by zero or more data flits on a narrow valid-ready link.
// The request side is ready-then-valid; readiness reopens combinationally in
// the cycle the last flit of a message transfers so messages stream back to
// back without a bubble.
module bp_lce_req_serializer #(
  parameter int hdr_width_p  = 64,
  parameter int data_width_p = 512,
  parameter int flit_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_lce_req_serializer_if.slave  bus
);

  localparam int max_beats_lp = data_width_p / flit_width_p;
  localparam int cnt_width_lp = (max_beats_lp + 1 > 1) ? $clog2(max_beats_lp + 1) : 1;
  localparam logic [cnt_width_lp-1:0] one_lp = cnt_width_lp'(1);

  typedef enum logic [1:0] {
    e_reset,
    e_ready,
    e_send_hdr,
    e_send_data
  } state_e;

  // Number of data flits for a request: payload bits over flit width, at
  // least one flit when data is present, saturating at the data register.
  function automatic logic [cnt_width_lp-1:0] beats_f(input logic [2:0] size,
                                                      input logic       has_data);
    int bits;
    int beats;
    bits  = 8 << size;
    beats = bits / flit_width_p;
    if (beats < 1)            beats = 1;
    if (beats > max_beats_lp) beats = max_beats_lp;
    if (!has_data)            beats = 0;
    return cnt_width_lp'(beats);
  endfunction

  state_e                  state_r;
  logic                    link_v_r;
  logic                    link_hdr_r;
  logic                    link_last_r;
  logic [flit_width_p-1:0] link_data_r;
  // Holds the data flits not yet presented; shifts down one flit per beat so
  // the next flit is always in the low slice.
  logic [data_width_p-1:0] data_r;
  logic [cnt_width_lp-1:0] beats_r;
  logic [cnt_width_lp-1:0] idx_r;

  logic xfer;
  logic msg_done;
  logic lce_req_ready;
  logic accept;

  // Handshake decode: a flit moves on valid & ready; the message is done when
  // the flit that moves is its last one.
  assign xfer          = link_v_r & bus.link_ready_i;
  assign msg_done      = xfer & link_last_r;
  assign lce_req_ready = (state_r == e_ready) | msg_done;
  assign accept        = bus.lce_req_v_i & lce_req_ready;

  assign bus.lce_req_ready_o = lce_req_ready;
  assign bus.link_v_o        = link_v_r;
  assign bus.link_hdr_o      = link_hdr_r;
  assign bus.link_last_o     = link_last_r;
  assign bus.link_data_o     = link_data_r;

  // Control FSM with registered flit outputs: captures a request on accept,
  // then walks header and data flits, holding everything while stalled.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the wide data holding register is a plain flop array, not a
      // memory macro, so it is cleared here; that guarantees a dropped message
      // can never leak stale bytes into a later flit.
      state_r     <= e_reset;
      link_v_r    <= 1'b0;
      link_hdr_r  <= 1'b0;
      link_last_r <= 1'b0;
      link_data_r <= '0;
      data_r      <= '0;
      beats_r     <= '0;
      idx_r       <= '0;
    end else begin
      // NOTE: every state update in this block is non-blocking so each branch
      // reads the pre-edge values of state_r, idx_r and data_r, matching the
      // combinational handshake decode above.
      if (state_r == e_reset) begin
        state_r <= e_ready;
      end else if (accept) begin
        // New message: present its header next cycle. Reached from e_ready or
        // from the last-flit transfer cycle of the previous message.
        state_r     <= e_send_hdr;
        link_v_r    <= 1'b1;
        link_hdr_r  <= 1'b1;
        link_last_r <= (beats_f(bus.lce_req_size_i, bus.lce_req_has_data_i) == '0);
        link_data_r <= flit_width_p'(bus.lce_req_header_i);
        data_r      <= bus.lce_req_data_i;
        beats_r     <= beats_f(bus.lce_req_size_i, bus.lce_req_has_data_i);
        idx_r       <= '0;
      end else if (xfer) begin
        if (link_last_r) begin
          // Message complete and nothing new arrived: go idle.
          state_r     <= e_ready;
          link_v_r    <= 1'b0;
          link_hdr_r  <= 1'b0;
          link_last_r <= 1'b0;
          link_data_r <= '0;
        end else if (state_r == e_send_hdr) begin
          // Header gone; first data flit is the low slice of the data.
          state_r     <= e_send_data;
          link_hdr_r  <= 1'b0;
          link_last_r <= (beats_r == one_lp);
          link_data_r <= data_r[flit_width_p-1:0];
          data_r      <= data_r >> flit_width_p;
          idx_r       <= '0;
        end else begin
          // Next data flit; it is last when its index reaches beats-1.
          link_last_r <= ((idx_r + one_lp) == (beats_r - one_lp));
          link_data_r <= data_r[flit_width_p-1:0];
          data_r      <= data_r >> flit_width_p;
          idx_r       <= idx_r + one_lp;
        end
      end
    end
  end

  // Protocol and configuration checks (ignored by synthesis).
  a_req_v_while_not_ready : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) bus.lce_req_v_i |-> lce_req_ready);

  a_hdr_fits_flit : assert property (
    @(posedge clk_i) hdr_width_p <= flit_width_p);

  a_data_multiple_of_flit : assert property (
    @(posedge clk_i) (data_width_p % flit_width_p) == 0);

endmodule
